register_file_scanner: RTL and testbench
========================================

Name: register_file_scanner

Overview:
- Reader-side sequencer for the 4-entry x 16-bit register file.
- On a start pulse it walks the register file's combinational read port from a first index to a last index, wrapping modulo NUM_REGS.
- It captures each entry and streams it out as (index, data) beats on a valid/ready handshake, then pulses done.
- It sits between the register file read port and a debug/dump consumer.

Parameters:
- DATA_WIDTH, 16, width of register contents.
- INDEX_WIDTH, 2, width of register index.
- NUM_REGS, 4, number of registers; equals 2**INDEX_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- first_index  input  INDEX_WIDTH  first register to read; latched when start is accepted.
- last_index  input  INDEX_WIDTH  last register to read; latched when start is accepted.
- rf_read_index  output  INDEX_WIDTH  drives the register file read_index_a.
- rf_read_data  input  DATA_WIDTH  from the register file read_data_a (combinational).
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  INDEX_WIDTH  index of the current beat.
- out_data  output  DATA_WIDTH  data of the current beat.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, any state, including mid-scan) takes effect immediately. Next state is IDLE.
- Outputs under reset: out_valid=0, out_index=0, out_data=0, rf_read_index=0, busy=0, done=0. Internal counter=0 and latched indices=0.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE, start=1:
  - Latch first_index into cur and last_index into last.
  - Set rf_read_index=first_index.
  - Go to FETCH.
  - start=0: stay in IDLE.
- FETCH:
  - rf_read_index holds cur.
  - At the posedge, capture out_data<=rf_read_data and out_index<=cur.
  - Go to SEND.
- SEND:
  - out_valid=1; out_data and out_index are held stable while out_ready=0.
  - On posedge with out_ready=1 and cur==last: go to DONE.
  - On posedge with out_ready=1 and cur!=last: cur<=cur+1 (modulo NUM_REGS, natural INDEX_WIDTH wrap), rf_read_index<=cur+1, go to FETCH.
  - out_valid drops in the cycle after acceptance.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start sampled at edge k gives out_valid high in the cycle after edge k+1.
  - Each subsequent beat is at best 2 cycles apart (FETCH then SEND).
  - A full 4-register scan with out_ready tied high takes 9 cycles from start to the done pulse.
- Beat count is ((last_index - first_index) mod NUM_REGS) + 1.
  - first==last gives a single beat.
  - last<first wraps through NUM_REGS-1 to 0.
- start while busy is ignored; it does not restart or queue a scan.
- rf_read_data is sampled only in FETCH. Register-file writes landing in the same cycle follow the register file's own timing (the pre-edge value is captured).
- out_valid must never be asserted in IDLE, FETCH or DONE.
- Width rules: all index arithmetic is INDEX_WIDTH bits with wrap; there is no saturation.

Decomposition:
- Shared package register_file_pkg holds:
  - DATA_WIDTH and INDEX_WIDTH constants, also used by register_file.
  - typedef rf_index_t and rf_data_t.
  - enum scanner_state_t {IDLE, FETCH, SEND, DONE}.
- No sub-module; the index counter and FSM are inline.
- Bench top instantiates register_file plus register_file_scanner.

Test Plan:
- Full scan, out_ready=1:
  - Stimulus: write regs 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444; start with first=0, last=3.
  - Response: beats (0,1111), (1,2222), (2,3333), (3,4444), each valid for one cycle; done pulses once, 9 cycles after start; busy high throughout.
- Wrap:
  - Stimulus: first=3, last=1.
  - Response: beats with indices 3, 0, 1 in that order, then done.
- Backpressure:
  - Stimulus: first=last=2, reg2=16'hBEEF; hold out_ready=0 for 5 cycles.
  - Response: out_valid=1 with out_data=16'hBEEF stable for all 5 cycles; accepted on the first ready cycle; done on the next cycle.
- Start while busy:
  - Stimulus: pulse start again during beat 1 of a 0..3 scan.
  - Response: scan completes unchanged, exactly 4 beats, 1 done pulse.
- Reset mid-scan:
  - Stimulus: assert reset asynchronously between edges while in SEND.
  - Response: out_valid, busy, rf_read_index and out_data all go to 0 immediately; no done pulse; a new start after reset yields a correct scan.
- Write during scan:
  - Stimulus: write reg1=16'hAAAA in the cycle the scanner is in FETCH for index 1.
  - Response: beat 1 carries the old reg1 value; a subsequent rescan shows 16'hAAAA.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and constants for the 4-entry register file and its read-side scanner.
package register_file_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int INDEX_WIDTH = 2;
    localparam int NUM_REGS    = 2 ** INDEX_WIDTH;

    typedef logic [DATA_WIDTH-1:0]  rf_data_t;
    typedef logic [INDEX_WIDTH-1:0] rf_index_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } scanner_state_t;
endpackage

// File: rtl/register_file.sv
// 4-entry register file: one synchronous write port, one combinational read port.
module register_file
    import register_file_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      write_enable,
    input  rf_index_t write_index,
    input  rf_data_t  write_data,
    input  rf_index_t read_index_a,
    output rf_data_t  read_data_a
);
    rf_data_t regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_enable) begin
            regs_q[write_index] <= write_data;
        end
    end

    assign read_data_a = regs_q[read_index_a];
endmodule

// File: rtl/register_file_scanner.sv
// Walks the register file read port from first_index to last_index (wrapping)
// and streams each entry as an (index, data) beat on a valid/ready handshake.
module register_file_scanner #(
    parameter int DATA_WIDTH  = register_file_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH = register_file_pkg::INDEX_WIDTH,
    parameter int NUM_REGS    = register_file_pkg::NUM_REGS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] first_index,
    input  logic [INDEX_WIDTH-1:0] last_index,
    output logic [INDEX_WIDTH-1:0] rf_read_index,
    input  logic [DATA_WIDTH-1:0]  rf_read_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   busy,
    output logic                   done
);
    import register_file_pkg::*;

    scanner_state_t         state_q, state_d;
    logic [INDEX_WIDTH-1:0] cur_q, cur_d;
    logic [INDEX_WIDTH-1:0] last_q, last_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [INDEX_WIDTH-1:0] cur_next;

    assign cur_next = INDEX_WIDTH'((int'(cur_q) + 1) % NUM_REGS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = first_index;
                    last_d  = last_index;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The read port is combinational, so this captures the pre-edge contents.
                out_data_d  = rf_read_data;
                out_index_d = cur_q;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (cur_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_next;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // cur_q doubles as the read address, so it is already presented during FETCH.
    assign rf_read_index = cur_q;
    assign out_valid     = (state_q == SEND);
    assign out_index     = out_index_q;
    assign out_data      = out_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
endmodule

// File: tb/tb_register_file_scanner.sv
// Scoreboard bench for register_file_scanner driving a real register_file.
module tb_register_file_scanner;
    import register_file_pkg::*;

    typedef struct {
        rf_index_t idx;
        rf_data_t  data;
    } beat_t;

    logic      clk = 1'b0;
    logic      reset;
    logic      start;
    rf_index_t first_index, last_index, rf_read_index;
    rf_data_t  rf_read_data;
    logic      out_valid, out_ready;
    rf_index_t out_index;
    rf_data_t  out_data;
    logic      busy, done;
    logic      we;
    rf_index_t wi;
    rf_data_t  wd;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beats_seen = 0;
    int exp_done = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    rf_data_t model_regs [NUM_REGS];

    logic      prev_valid, prev_ready;
    rf_index_t prev_idx;
    rf_data_t  prev_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    register_file u_rf (
        .clk          (clk),
        .reset        (reset),
        .write_enable (we),
        .write_index  (wi),
        .write_data   (wd),
        .read_index_a (rf_read_index),
        .read_data_a  (rf_read_data)
    );

    register_file_scanner dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .first_index   (first_index),
        .last_index    (last_index),
        .rf_read_index (rf_read_index),
        .rf_read_data  (rf_read_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every accepted beat and checks handshake rules.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (!busy) chk("valid_while_idle", 32'(out_valid), 32'd0);
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_index", 32'(out_index), 32'(prev_idx));
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end else if (prev_valid && prev_ready) begin
                chk("valid_drop_after_accept", 32'(out_valid), 32'd0);
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got index %0d data %h, expected no beat", out_index, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_index", 32'(out_index), 32'(mon_e.idx));
                    chk("beat_data", 32'(out_data), 32'(mon_e.data));
                end
            end
            if (done) begin
                if (exp_done == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_done: got done pulse, expected none");
                end else begin
                    exp_done--;
                    chk("beats_left_at_done", 32'(exp_q.size()), 32'd0);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_idx   = out_index;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input rf_index_t i, input rf_data_t d);
        we = 1'b1;
        wi = i;
        wd = d;
        tick();
        we = 1'b0;
        model_regs[i] = d;
    endtask

    task automatic start_scan(input rf_index_t f, input rf_index_t l, output int start_cyc);
        int n;
        beat_t b;
        n = ((int'(l) - int'(f) + NUM_REGS) % NUM_REGS) + 1;
        for (int k = 0; k < n; k++) begin
            b.idx  = rf_index_t'((int'(f) + k) % NUM_REGS);
            b.data = model_regs[b.idx];
            exp_q.push_back(b);
        end
        exp_done++;
        start       = 1'b1;
        first_index = f;
        last_index  = l;
        start_cyc   = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int done_cyc, output int idle_cycles);
        done_cyc    = -1;
        idle_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!busy) idle_cycles++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        chk("done_within_budget", 32'(done_cyc >= 0), 32'd1);
        if (done_cyc >= 0) tick();
    endtask

    task automatic wait_negedge_until_valid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("valid_within_budget", 32'(seen), 32'd1);
    endtask

    initial begin
        int sc, dc, idl, b0;
        bit found;
        reset = 1'b1;
        start = 1'b0;
        first_index = '0;
        last_index = '0;
        out_ready = 1'b0;
        we = 1'b0;
        wi = '0;
        wd = '0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_index", 32'(rf_read_index), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        reset = 1'b0;
        tick();

        // Full scan with ready held high.
        rf_write(0, 16'h1111);
        rf_write(1, 16'h2222);
        rf_write(2, 16'h3333);
        rf_write(3, 16'h4444);
        out_ready = 1'b1;
        start_scan(0, 3, sc);
        wait_done(40, 1'b0, dc, idl);
        chk("full_scan_latency", 32'(dc - sc), 32'd9);
        chk("full_scan_busy", 32'(idl), 32'd0);

        // Wrap-around scan.
        start_scan(3, 1, sc);
        wait_done(40, 1'b0, dc, idl);

        // Backpressure on a single-beat scan.
        rf_write(2, 16'hBEEF);
        out_ready = 1'b0;
        start_scan(2, 2, sc);
        wait_negedge_until_valid(10);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h0000BEEF);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_at_accept", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_done_next", 32'(done), 32'd1);
        tick();

        // Start pulse while busy is ignored.
        b0 = beats_seen;
        start_scan(0, 3, sc);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_index == 2'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("busy_beat1_seen", 32'(found), 32'd1);
        start = 1'b1;
        first_index = 2'd2;
        last_index = 2'd2;
        tick();
        start = 1'b0;
        wait_done(40, 1'b0, dc, idl);
        chk("busy_beat_count", 32'(beats_seen - b0), 32'd4);
        @(negedge clk);
        chk("busy_no_restart", 32'(busy), 32'd0);
        tick();

        // Asynchronous reset in the middle of SEND.
        out_ready = 1'b0;
        start_scan(0, 3, sc);
        wait_negedge_until_valid(10);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_index", 32'(rf_read_index), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        exp_done = 0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'd0);
            tick();
        end
        rf_write(1, 16'h5A5A);
        rf_write(2, 16'hC3C3);
        out_ready = 1'b1;
        start_scan(1, 2, sc);
        wait_done(40, 1'b0, dc, idl);

        // Write landing in the FETCH cycle of index 1 is not seen by this scan.
        rf_write(1, 16'h1234);
        start_scan(0, 3, sc);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && !out_valid && rf_read_index == 2'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("fetch1_seen", 32'(found), 32'd1);
        we = 1'b1;
        wi = 2'd1;
        wd = 16'hAAAA;
        tick();
        we = 1'b0;
        wait_done(40, 1'b0, dc, idl);
        model_regs[1] = 16'hAAAA;
        start_scan(1, 1, sc);
        wait_done(40, 1'b0, dc, idl);

        // Randomized scans with random writes and random backpressure.
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) begin
                rf_write(rf_index_t'($urandom_range(0, NUM_REGS - 1)), rf_data_t'($urandom));
            end
            start_scan(rf_index_t'($urandom_range(0, NUM_REGS - 1)),
                       rf_index_t'($urandom_range(0, NUM_REGS - 1)), sc);
            wait_done(300, 1'b1, dc, idl);
            out_ready = 1'b0;
        end

        repeat (2) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_done_count", 32'(exp_done), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
